// File: rtl/mfp_spi_read_arbiter.sv
// Round-robin shared SPI read master for two requesters; gnt one cycle after accept, rd_valid CS_SETUP+2*N_BITS*CLK_DIV+CLK_DIV cycles after gnt.
// No backpressure: requests arriving while busy are held off (no gnt) and re-evaluated in the next idle cycle.
module mfp_spi_read_arbiter #(
  parameter int CLK_DIV  = 4,
  parameter int N_BITS   = 16,
  parameter int CS_SETUP = 2
) (
  input  logic              SI_ClkIn,
  input  logic              SI_Reset,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic [N_BITS-1:0] rd_data,
  output logic [1:0]        rd_valid,
  output logic              busy,
  output logic              SPI_CS,
  output logic              SPI_SCK,
  input  logic              SPI_SDO
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [N_BITS-1:0] shreg;
  logic              owner;
  logic              last_srv;
  logic              pick;

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    pick = 1'b0;
    unique case (req)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_srv;
      default: pick = 1'b0;
    endcase
  end

  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      owner    <= 1'b0;
      last_srv <= 1'b1;
      gnt      <= 2'b00;
      rd_valid <= 2'b00;
      rd_data  <= '0;
      busy     <= 1'b0;
      SPI_CS   <= 1'b1;
      SPI_SCK  <= 1'b1;
    end else begin
      gnt      <= 2'b00;
      rd_valid <= 2'b00;
      unique case (state)
        IDLE: begin
          SPI_CS  <= 1'b1;
          SPI_SCK <= 1'b1;
          cnt     <= '0;
          if (req != 2'b00) begin
            state  <= SETUP;
            owner  <= pick;
            gnt    <= pick ? 2'b10 : 2'b01;
            busy   <= 1'b1;
            SPI_CS <= 1'b0;
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state   <= SHIFT;
            cnt     <= '0;
            bit_cnt <= '0;
            SPI_SCK <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // SCK itself tells which half of the period is running.
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!SPI_SCK) begin
              SPI_SCK <= 1'b1;
              shreg   <= N_BITS'({shreg, SPI_SDO});
            end else if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              SPI_SCK <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (cnt == DIV_LAST) begin
            state    <= DONE;
            cnt      <= '0;
            SPI_CS   <= 1'b1;
            rd_data  <= shreg;
            rd_valid <= owner ? 2'b10 : 2'b01;
            last_srv <= owner;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_spi_read_arbiter.sv
// Bench for mfp_spi_read_arbiter: default-parameter instance plus a fast small instance.
module tb_mfp_spi_read_arbiter;

  localparam int CD     = 4;
  localparam int NB     = 16;
  localparam int CSS    = 2;
  localparam int LAT_RV = 1 + CSS + 2 * NB * CD + CD;
  localparam int CS_LOW = CSS + 2 * NB * CD + CD;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, gnt, rd_valid;
  logic [15:0] rd_data;
  logic        busy, cs, sck, sdo;
  logic [1:0]  req2, gnt2, rv2;
  logic [7:0]  rd_data2;
  logic        busy2, cs2, sck2, sdo2;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int m_last = 1;
  logic [15:0] slave_word = 16'h0000;
  logic [7:0]  slave_word2 = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mfp_spi_read_arbiter dut (
    .SI_ClkIn(clk), .SI_Reset(rst), .req(req), .gnt(gnt), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .SPI_CS(cs), .SPI_SCK(sck), .SPI_SDO(sdo)
  );

  mfp_spi_read_arbiter #(.CLK_DIV(1), .N_BITS(8), .CS_SETUP(1)) dut2 (
    .SI_ClkIn(clk), .SI_Reset(rst), .req(req2), .gnt(gnt2), .rd_data(rd_data2),
    .rd_valid(rv2), .busy(busy2), .SPI_CS(cs2), .SPI_SCK(sck2), .SPI_SDO(sdo2)
  );

  // Slave models: next bit on each SCK fall, noise whenever SCK is high or CS is idle.
  int   sidx = 0, sidx2 = 0;
  logic psck = 1'b1, psck2 = 1'b1;
  always @(negedge clk) begin
    if (cs) begin
      sidx = 0;
      sdo  = 1'($urandom);
    end else if (psck && !sck) begin
      sdo  = slave_word[NB-1-sidx];
      sidx++;
    end else if (sck) begin
      sdo = 1'($urandom);
    end
    psck = sck;
  end

  always @(negedge clk) begin
    if (cs2) begin
      sidx2 = 0;
      sdo2  = 1'($urandom);
    end else if (psck2 && !sck2) begin
      sdo2  = slave_word2[7-sidx2];
      sidx2++;
    end else if (sck2) begin
      sdo2 = 1'($urandom);
    end
    psck2 = sck2;
  end

  always @(negedge clk) begin
    if ((gnt | rd_valid) != 2'b00) begin
      checks++;
      if (!$onehot0(gnt) || !$onehot0(rd_valid) ||
          (gnt != 2'b00 && rd_valid != 2'b00 && gnt != rd_valid)) begin
        errors++;
        $display("FAIL onehot: gnt=%b rd_valid=%b, required one-hot and same owner", gnt, rd_valid);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output int t, output logic [1:0] g, output int hi);
    t = -1; g = 2'b00; hi = cs ? 1 : 0;
    for (int i = 0; i < 400 && t < 0; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin t = cyc; g = gnt; end
      else if (cs) hi++;
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: no grant in 400 cycles, required one");
    end
  endtask

  task automatic wait_rv(output int t, output int lo, output int ri);
    logic p;
    p = sck; t = -1; ri = 0; lo = cs ? 0 : 1;
    for (int i = 0; i < 400 && t < 0; i++) begin
      @(negedge clk);
      if (rd_valid != 2'b00) t = cyc;
      else begin
        if (!cs) lo++;
        if (sck && !p) ri++;
      end
      p = sck;
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL rv_timeout: no rd_valid in 400 cycles, required one");
    end
  endtask

  task automatic txn(input string tag, input logic [1:0] r, input logic [15:0] w, input logic [1:0] eo);
    int t0, tg, tv, hi, lo, ri;
    logic [1:0] g;
    slave_word = w;
    @(negedge clk);
    req = r; t0 = cyc;
    wait_gnt(tg, g, hi);
    req = 2'b00;
    chk({tag, "_gnt"}, 32'(g), 32'(eo));
    chk({tag, "_gnt_lat"}, 32'(tg - t0), 1);
    wait_rv(tv, lo, ri);
    chk({tag, "_rv_owner"}, 32'(rd_valid), 32'(eo));
    chk({tag, "_data"}, 32'(rd_data), 32'(w));
    chk({tag, "_rv_lat"}, 32'(tv - t0), LAT_RV);
    chk({tag, "_cs_low"}, 32'(lo), CS_LOW);
    chk({tag, "_sck_rises"}, 32'(ri), NB);
    chk({tag, "_busy_done"}, 32'(busy), 1);
    @(negedge clk);
    chk({tag, "_busy_clr"}, 32'(busy), 0);
    chk({tag, "_idle_pins"}, 32'({cs, sck}), 32'(2'b11));
    m_last = eo[1] ? 1 : 0;
  endtask

  typedef struct {
    logic [1:0]  r;
    logic [15:0] w;
    logic [1:0]  eg;
  } vec_t;
  vec_t vt[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0, tg, tv, hi, lo, ri, ng, bad, lr, nrv;
    logic [1:0] g, eg;
    logic p;
    logic [15:0] hw[4];

    vt[0] = '{2'b11, 16'h0F0F, 2'b10};
    vt[1] = '{2'b11, 16'hFFFF, 2'b01};
    vt[2] = '{2'b10, 16'h0000, 2'b10};
    vt[3] = '{2'b10, 16'h8001, 2'b10};
    vt[4] = '{2'b11, 16'h7FFE, 2'b01};
    vt[5] = '{2'b01, 16'h1357, 2'b01};
    vt[6] = '{2'b11, 16'hCAFE, 2'b10};

    // Reset held with both requests asserted.
    rst = 1'b1; req = 2'b11; req2 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_pins", 32'({cs, sck}), 32'(2'b11));
      chk("rst_gnt_rv", 32'({gnt, rd_valid}), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data", 32'(rd_data), 0);
    end
    rst = 1'b0; req = 2'b00; req2 = 2'b00;

    txn("basic", 2'b01, 16'hA5C3, 2'b01);

    for (int i = 0; i < 7; i++) txn("vec", vt[i].r, vt[i].w, vt[i].eg);

    // Both requests held: strict alternation with a 2-cycle CS-high gap.
    hw[0] = 16'h3C3C; hw[1] = 16'hC3C3; hw[2] = 16'h0001; hw[3] = 16'h8000;
    tv = 0;
    @(negedge clk);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(tg, g, hi);
      slave_word = hw[i];
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("held_gnt", 32'(g), 32'(eg));
      if (i > 0) begin
        chk("held_gnt_after_rv", 32'(tg - tv), 2);
        chk("held_cs_gap", 32'(hi), 2);
      end
      wait_rv(tv, lo, ri);
      chk("held_rv_owner", 32'(rd_valid), 32'(eg));
      chk("held_data", 32'(rd_data), 32'(hw[i]));
    end
    req = 2'b00;
    @(negedge clk);
    m_last = 1;

    // Second request raised mid-shift waits for the first to finish.
    slave_word = 16'h6B2D;
    @(negedge clk);
    req = 2'b01;
    wait_gnt(tg, g, hi);
    req = 2'b00;
    chk("mid_gnt0", 32'(g), 32'(2'b01));
    repeat (40) @(negedge clk);
    req = 2'b10;
    ng = 0; tv = -1;
    for (int i = 0; i < 200 && tv < 0; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) ng++;
      if (rd_valid != 2'b00) tv = cyc;
    end
    chk("mid_no_gnt", 32'(ng), 0);
    chk("mid_rv0", 32'(rd_valid), 32'(2'b01));
    chk("mid_data0", 32'(rd_data), 32'h6B2D);
    slave_word = 16'h9E47;
    wait_gnt(tg, g, hi);
    req = 2'b00;
    chk("mid_gnt1", 32'(g), 32'(2'b10));
    chk("mid_gnt1_lat", 32'(tg - tv), 2);
    wait_rv(tv, lo, ri);
    chk("mid_rv1", 32'(rd_valid), 32'(2'b10));
    chk("mid_data1", 32'(rd_data), 32'h9E47);
    @(negedge clk);
    m_last = 1;

    // Reset during the 8th SCK period.
    slave_word = 16'hFFFF;
    @(negedge clk);
    req = 2'b01;
    wait_gnt(tg, g, hi);
    req = 2'b00;
    while (cyc < tg + CSS + 7 * 2 * CD + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_pins", 32'({cs, sck}), 32'(2'b11));
    chk("mrst_gnt_rv", 32'({gnt, rd_valid}), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_data", 32'(rd_data), 0);
    rst = 1'b0;
    m_last = 1;
    nrv = 0;
    repeat (150) begin
      @(negedge clk);
      if (rd_valid != 2'b00 || !cs) nrv++;
    end
    chk("mrst_quiet", 32'(nrv), 0);
    txn("after_rst", 2'b11, 16'h1234, 2'b01);

    // Random traffic against the arbitration and timing rules.
    for (int n = 0; n < 20; n++) begin
      logic [1:0]  rr, eo;
      logic [15:0] ww;
      rr = 2'($urandom_range(1, 3));
      ww = 16'($urandom);
      if (rr != 2'b11) eo = rr;
      else eo = (m_last == 1) ? 2'b01 : 2'b10;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      txn("rand", rr, ww, eo);
    end

    // Small fast instance: CLK_DIV=1, N_BITS=8, CS_SETUP=1.
    slave_word2 = 8'h5A;
    @(negedge clk);
    req2 = 2'b01; t0 = cyc; tg = -1;
    for (int i = 0; i < 20 && tg < 0; i++) begin
      @(negedge clk);
      if (gnt2 != 2'b00) tg = cyc;
    end
    chk("d2_gnt", 32'(gnt2), 32'(2'b01));
    chk("d2_gnt_lat", 32'(tg - t0), 1);
    req2 = 2'b00;
    p = sck2; ri = 0; bad = 0; lr = -1; tv = -1;
    for (int i = 0; i < 100 && tv < 0; i++) begin
      @(negedge clk);
      if (rv2 != 2'b00) tv = cyc;
      else if (sck2 && !p) begin
        ri++;
        if (lr >= 0 && cyc - lr != 2) bad++;
        lr = cyc;
      end
      p = sck2;
    end
    chk("d2_rv_lat", 32'(tv - t0), 19);
    chk("d2_rv", 32'(rv2), 32'(2'b01));
    chk("d2_data", 32'(rd_data2), 32'h5A);
    chk("d2_sck_rises", 32'(ri), 8);
    chk("d2_sck_period", 32'(bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
